datapath: RTL

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module   : datapath
// Brief    : Microcoded accumulator datapath (PC/MAR/MBR/IR/BR/ACC) with a
//            three-state memory handshake; signed multiplier, P and MR are
//            present only when DATAPATH_MPY_EN is defined.
// Revision : 1.0
// ============================================================================
module datapath #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   control_signal,
  input  logic          ctrl_valid,
  output logic [7:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_ready,
  output logic [7:0]    data_to_cu,
  output logic [7:0]    flags,
  output logic          busy
);

  localparam int c_mar2memory  = 0;
  localparam int c_pc2mbr      = 1;
  localparam int c_pc2mar      = 2;
  localparam int c_mbr2pc      = 3;
  localparam int c_mbr2ir      = 4;
  localparam int c_memory2mbr  = 5;
  localparam int c_mbr2br      = 6;
  localparam int c_mbr2mar     = 8;
  localparam int c_mbr2acc     = 10;
  localparam int c_acc2mbr     = 11;
  localparam int c_mbr2memory  = 12;
  localparam int c_ir2cu       = 13;
  localparam int c_mr2mbr      = 15;
  localparam int c_mpy_alu2mr  = 16;
  localparam int c_pc_plus1    = 20;
  localparam int c_acc_clear   = 21;
  localparam int c_alu_add     = 22;
  localparam int c_alu_sub     = 23;
  localparam int c_alu_and     = 24;
  localparam int c_alu_or      = 25;
  localparam int c_alu_not     = 26;
  localparam int c_alu_shl     = 27;
  localparam int c_alu_shr     = 28;
  localparam int c_alu_mpy     = 29;
  localparam int c_alu_ashl    = 30;
  localparam int c_alu_ashr    = 31;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } mem_state_t;

  mem_state_t    r_state, w_state_nxt;
  logic [31:0]   w_cs;
  logic [7:0]    r_pc, r_mar;
  logic [DW-1:0] r_mbr, r_ir, r_br, r_acc, r_mdr;
  logic          r_pending, r_carry;
  logic          w_start_rd, w_start_wr, w_done, w_rd_done, w_mem2mbr_busy;
  logic [DW:0]   w_sum, w_diff;
  logic [3:0]    w_sh;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_hit, w_alu_cy;
  logic [DW-1:0] w_mr, w_p_lo;
  logic          w_mpy_acc_ld;
  logic          w_unused;

  // A control word only acts on its strobe cycle.
  assign w_cs           = ctrl_valid ? control_signal : 32'd0;
  assign busy           = (r_state != S_IDLE);
  assign flags          = {5'd0, r_carry, (r_acc == '0), r_acc[DW-1]};
  assign w_rd_done      = w_done && (r_state == S_RD_WAIT);
  assign w_mem2mbr_busy = w_cs[c_memory2mbr] && busy;

  // ---------------------------------------------------------------- memory FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs[c_mbr2memory]) begin
          w_start_wr  = 1'b1;
          w_state_nxt = S_WR_WAIT;
        end else if (w_cs[c_mar2memory]) begin
          w_start_rd  = 1'b1;
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= '0;
    end else if (w_start_rd) begin
      mem_rd    <= 1'b1;
      mem_addr  <= r_mar;
    end else if (w_start_wr) begin
      mem_wr    <= 1'b1;
      mem_addr  <= r_mar;
      mem_wdata <= r_mbr;
    end else if (w_done) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= '0;
    end
  end

  // ---------------------------------------------------------------------- ALU
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_br};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_br};
  assign w_sh   = r_br[3:0];

  // Lowest-numbered ALU bit wins; carry only moves on add/sub.
  always_comb begin
    w_alu_hit = 1'b1;
    w_alu_res = r_acc;
    w_alu_cy  = r_carry;
    if (w_cs[c_alu_add]) begin
      w_alu_res = w_sum[DW-1:0];
      w_alu_cy  = w_sum[DW];
    end else if (w_cs[c_alu_sub]) begin
      w_alu_res = w_diff[DW-1:0];
      w_alu_cy  = w_diff[DW];
    end else if (w_cs[c_alu_and]) begin
      w_alu_res = r_acc & r_br;
    end else if (w_cs[c_alu_or]) begin
      w_alu_res = r_acc | r_br;
    end else if (w_cs[c_alu_not]) begin
      w_alu_res = ~r_br;
    end else if (w_cs[c_alu_shl]) begin
      w_alu_res = r_acc << w_sh;
    end else if (w_cs[c_alu_shr]) begin
      w_alu_res = r_acc >> w_sh;
    end else if (w_cs[c_alu_ashl]) begin
      w_alu_res = r_acc <<< w_sh;
    end else if (w_cs[c_alu_ashr]) begin
      w_alu_res = $signed(r_acc) >>> w_sh;
    end else begin
      w_alu_hit = 1'b0;
    end
  end

  // --------------------------------------------------------------- multiplier
`ifdef DATAPATH_MPY_EN
  logic [2*DW-1:0] r_p;
  logic [DW-1:0]   r_mr;
  logic [2*DW-1:0] w_acc_sx, w_br_sx, w_prod;

  // Sign-extended operands make the low 2*DW product bits the signed product.
  assign w_acc_sx = {{DW{r_acc[DW-1]}}, r_acc};
  assign w_br_sx  = {{DW{r_br[DW-1]}}, r_br};
  assign w_prod   = w_acc_sx * w_br_sx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p  <= '0;
      r_mr <= '0;
    end else begin
      if (w_cs[c_alu_mpy])    r_p  <= w_prod;
      if (w_cs[c_mpy_alu2mr]) r_mr <= r_p[2*DW-1:DW];
    end
  end

  assign w_mr         = r_mr;
  assign w_p_lo       = r_p[DW-1:0];
  assign w_mpy_acc_ld = w_cs[c_mpy_alu2mr];
`else
  assign w_mr         = '0;
  assign w_p_lo       = '0;
  assign w_mpy_acc_ld = 1'b0;
`endif

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= 8'd0;
      r_mar      <= 8'd0;
      r_mbr      <= '0;
      r_ir       <= '0;
      r_br       <= '0;
      r_acc      <= '0;
      r_mdr      <= '0;
      r_pending  <= 1'b0;
      r_carry    <= 1'b0;
      data_to_cu <= 8'd0;
    end else begin
      if (w_cs[c_mbr2pc])        r_pc <= r_mbr[7:0];
      else if (w_cs[c_pc_plus1]) r_pc <= r_pc + 8'd1;

      if (w_cs[c_mbr2mar])       r_mar <= r_mbr[7:0];
      else if (w_cs[c_pc2mar])   r_mar <= r_pc;

      if (w_cs[c_mbr2ir]) r_ir       <= r_mbr;
      if (w_cs[c_mbr2br]) r_br       <= r_mbr;
      if (w_cs[c_ir2cu])  data_to_cu <= r_ir[DW-1:DW-8];
      if (w_rd_done)      r_mdr      <= mem_rdata;

      // A memory2mbr issued mid-access is remembered until the access ends.
      r_pending <= (r_pending | w_mem2mbr_busy) & ~w_done;

      if ((r_pending || w_mem2mbr_busy) && w_rd_done) r_mbr <= mem_rdata;
      else if (w_cs[c_memory2mbr] && !busy)            r_mbr <= r_mdr;
      else if (w_cs[c_acc2mbr])                        r_mbr <= r_acc;
      else if (w_cs[c_mr2mbr])                         r_mbr <= w_mr;
      else if (w_cs[c_pc2mbr])                         r_mbr <= {{(DW-8){1'b0}}, r_pc};

      if (w_cs[c_acc_clear]) begin
        r_acc <= '0;
      end else if (w_alu_hit) begin
        r_acc   <= w_alu_res;
        r_carry <= w_alu_cy;
      end else if (w_mpy_acc_ld) begin
        r_acc <= w_p_lo;
      end else if (w_cs[c_mbr2acc]) begin
        r_acc <= r_mbr;
      end
    end
  end

  // Reserved control bits and the IR address field have no effect here.
  assign w_unused = ^{w_cs[c_alu_mpy], w_cs[c_mpy_alu2mr], w_cs[7], w_cs[9],
                      w_cs[14], w_cs[19:17], r_ir[DW-9:0]};

endmodule
`default_nettype wire
